// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sequencer in front of one shared registered adder.
// It accepts one operand pair per grant, waits out the adder latency, captures
// the sum and returns it with the owner's ID over a valid/ready response channel.
module adder_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int W       = 16,
  parameter int ADD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*W-1:0]  req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [W:0]         resp_sum,
  output logic               resp_carry,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic [W:0]         add_sum,
  output logic               busy,
  output logic [15:0]        ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] gnt_q;
  logic [2:0]      cnt_q;
  logic [W-1:0]    add_a_q, add_b_q;
  logic            resp_valid_q;
  logic [ID_W-1:0] resp_id_q;
  logic [W:0]      resp_sum_q;
  logic            resp_carry_q;
  logic [15:0]     ops_done_q;

  logic                 win_found_s;
  logic [ID_W-1:0]      win_idx_s;
  logic [2**ID_W-1:0]   valid_pad_s;
  logic [W-1:0]         sel_a_s, sel_b_s;

  // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
  always_comb begin
    logic [ID_W:0] pos_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    pos_v       = '0;
    valid_pad_s = (2**ID_W)'(req_valid);
    for (int k = 0; k < NREQ; k++) begin
      pos_v = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (pos_v >= (ID_W+1)'(NREQ)) begin
        pos_v = pos_v - (ID_W+1)'(NREQ);
      end else begin
        pos_v = pos_v;
      end
      if (!win_found_s && valid_pad_s[pos_v[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = pos_v[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Operand mux selecting the winner's A/B slices.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx_s == ID_W'(j)) begin
        sel_a_s = req_a[j*W +: W];
        sel_b_s = req_b[j*W +: W];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) state_d = ST_WAIT;
        else             state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               state_d = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
        else            state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant is one-hot only while idle, busy otherwise.
  always_comb begin
    req_ready = '0;
    busy      = (state_q != ST_IDLE);
    if (state_q == ST_IDLE && win_found_s) begin
      req_ready = NREQ'(1'b1) << win_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Datapath: operand latch on accept, latency countdown, sum capture, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= 3'd0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found_s) begin
            add_a_q <= sel_a_s;
            add_b_q <= sel_b_s;
            gnt_q   <= win_idx_s;
            cnt_q   <= 3'(ADD_LAT);
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            resp_sum_q   <= add_sum;
            resp_carry_q <= add_sum[W];
            resp_id_q    <= gnt_q;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            ops_done_q   <= ops_done_q + 16'd1;
            ptr_q        <= (gnt_q == ID_W'(NREQ-1)) ? '0 : gnt_q + ID_W'(1);
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: stimulus pushes expected responses,
// a monitor thread pops and compares on every response handshake.
module tb_adder_rr_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int W    = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W:0]      sum;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // default-latency DUT signals
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              resp_valid, resp_ready, resp_carry, busy;
  logic [ID_W-1:0]   resp_id;
  logic [W:0]        resp_sum, add_sum;
  logic [W-1:0]      add_a, add_b;
  logic [15:0]       ops_done;

  // latency-3 DUT signals
  logic [NREQ-1:0]   req_valid2, req_ready2;
  logic [NREQ*W-1:0] req_a2, req_b2;
  logic              resp_valid2, resp_ready2, resp_carry2, busy2;
  logic [ID_W-1:0]   resp_id2;
  logic [W:0]        resp_sum2, add_sum2, s1_2, s2_2;
  logic [W-1:0]      add_a2, add_b2;
  logic [15:0]       ops_done2;

  adder_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .W(W), .ADD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_carry(resp_carry),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .busy(busy), .ops_done(ops_done));

  adder_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .W(W), .ADD_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_id(resp_id2), .resp_sum(resp_sum2), .resp_carry(resp_carry2),
    .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2), .busy(busy2), .ops_done(ops_done2));

  // shared adder model, latency 1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) add_sum <= '0;
    else        add_sum <= {1'b0, add_a} + {1'b0, add_b};
  end

  // shared adder model, latency 3
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_2 <= '0; s2_2 <= '0; add_sum2 <= '0;
    end else begin
      s1_2 <= {1'b0, add_a2} + {1'b0, add_b2};
      s2_2 <= s1_2;
      add_sum2 <= s2_2;
    end
  end

  int   n_checks;
  int   n_errors;
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit d2, input int id, input logic [W:0] sum);
    exp_t e;
    e.id  = ID_W'(id);
    e.sum = sum;
    if (d2) q2.push_back(e);
    else    q1.push_back(e);
  endtask

  task automatic set_req(input bit d2, input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    if (d2) begin
      req_a2[i*W +: W] = a; req_b2[i*W +: W] = b; req_valid2[i] = 1'b1;
    end else begin
      req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1;
    end
  endtask

  task automatic clr_req(input bit d2, input int i);
    if (d2) begin
      req_valid2[i] = 1'b0; req_a2[i*W +: W] = 16'hDEAD; req_b2[i*W +: W] = 16'hBEEF;
    end else begin
      req_valid[i] = 1'b0; req_a[i*W +: W] = 16'hDEAD; req_b[i*W +: W] = 16'hBEEF;
    end
  endtask

  // waits for requester i to be granted, returns at accept edge + 1
  task automatic wait_accept(input bit d2, input int i);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if ((d2 ? req_ready2[i] : req_ready[i]) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL grant_timeout: req %0d never granted, required grant within 60 cycles", i);
      clr_req(d2, i);
    end else begin
      chk("req_ready_onehot", d2 ? 32'(req_ready2) : 32'(req_ready), 32'd1 << i);
      @(posedge clk); #1;
      clr_req(d2, i);
    end
  endtask

  // counts edges from the accept edge until resp_valid is seen
  task automatic wait_resp(input bit d2, output int lat);
    lat = -1;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if ((d2 ? resp_valid2 : resp_valid) === 1'b1) begin
        lat = t;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk);
    end
    chk("scoreboard_drain", 32'(q1.size() + q2.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // monitor: compares every response handshake against the scoreboard head
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_resp: got id %0d sum 0x%0h, required none", resp_id, resp_sum);
        end else begin
          e = q1.pop_front();
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_sum", 32'(resp_sum), 32'(e.sum));
          chk("resp_carry", 32'(resp_carry), 32'(e.sum[W]));
        end
      end
      if (rst_n && resp_valid2 && resp_ready2) begin
        if (q2.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_resp2: got id %0d sum 0x%0h, required none", resp_id2, resp_sum2);
        end else begin
          e = q2.pop_front();
          chk("resp_id2", 32'(resp_id2), 32'(e.id));
          chk("resp_sum2", 32'(resp_sum2), 32'(e.sum));
          chk("resp_carry2", 32'(resp_carry2), 32'(e.sum[W]));
        end
      end
    end
  endtask

  initial begin
    int lat;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0; resp_ready2 = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_resp_sum", 32'(resp_sum), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single request
    push(1'b0, 0, 17'd17);
    set_req(1'b0, 0, 16'd8, 16'd9);
    wait_accept(1'b0, 0);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_add_a", 32'(add_a), 32'd8);
    chk("single_add_b", 32'(add_b), 32'd9);
    wait_resp(1'b0, lat);
    chk("single_latency", 32'(lat), 32'd2);
    drain();
    chk("single_ops_done", 32'(ops_done), 32'd1);
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // reset pulse so the pointer starts at 0
    rst_n = 1'b0; #1;
    chk("pulse_ops_done", 32'(ops_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // contention: all four valid, expect ID order 0..3
    push(1'b0, 0, 17'd24); push(1'b0, 1, 17'd27); push(1'b0, 2, 17'd37); push(1'b0, 3, 17'd62);
    set_req(1'b0, 0, 16'd11, 16'd13);
    set_req(1'b0, 1, 16'd10, 16'd17);
    set_req(1'b0, 2, 16'd13, 16'd24);
    set_req(1'b0, 3, 16'd27, 16'd35);
    for (int i = 0; i < 4; i++) wait_accept(1'b0, i);
    drain();
    chk("cont_ops_done", 32'(ops_done), 32'd4);

    // only req 1 and 3: req 1 first
    push(1'b0, 1, 17'd300); push(1'b0, 3, 17'd3000);
    set_req(1'b0, 3, 16'd1000, 16'd2000);
    set_req(1'b0, 1, 16'd100, 16'd200);
    wait_accept(1'b0, 1);
    wait_accept(1'b0, 3);
    drain();

    // carry cases
    push(1'b0, 2, 17'h10000);
    set_req(1'b0, 2, 16'hFFFF, 16'h0001);
    wait_accept(1'b0, 2);
    push(1'b0, 3, 17'h1FFFE);
    set_req(1'b0, 3, 16'hFFFF, 16'hFFFF);
    wait_accept(1'b0, 3);
    drain();
    chk("carry_ops_done", 32'(ops_done), 32'd8);

    // backpressure on req 1, with req 2 waiting behind it
    resp_ready = 1'b0;
    push(1'b0, 1, 17'd86);
    set_req(1'b0, 1, 16'd39, 16'd47);
    wait_accept(1'b0, 1);
    wait_resp(1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd2);
    push(1'b0, 2, 17'd3);
    set_req(1'b0, 2, 16'd1, 16'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_sum", 32'(resp_sum), 32'd86);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_add_a_hold", 32'(add_a), 32'd39);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ops_done", 32'(ops_done), 32'd9);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    wait_accept(1'b0, 2);
    drain();

    // reset during WAIT drops the operation
    set_req(1'b0, 0, 16'd57, 16'd75);
    wait_accept(1'b0, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_add_a", 32'(add_a), 32'd0);
    chk("mid_add_b", 32'(add_b), 32'd0);
    chk("mid_ops_done", 32'(ops_done), 32'd0);
    chk("mid_resp_sum", 32'(resp_sum), 32'd0);
    chk("mid_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1'b0, 1, 17'd11); push(1'b0, 3, 17'd158);
    set_req(1'b0, 3, 16'd77, 16'd81);
    set_req(1'b0, 1, 16'd5, 16'd6);
    wait_accept(1'b0, 1);
    wait_accept(1'b0, 3);
    drain();
    chk("post_rst_ops_done", 32'(ops_done), 32'd2);

    // latency-3 instance
    push(1'b1, 0, 17'd172);
    set_req(1'b1, 0, 16'd83, 16'd89);
    wait_accept(1'b1, 0);
    wait_resp(1'b1, lat);
    chk("lat3_latency", 32'(lat), 32'd4);
    drain();
    chk("lat3_ops_done", 32'(ops_done2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
